// File: rtl/spi_pkg.sv
// Shared types and sizing helpers for the buffered SPI master.
// Contents:
//   state_t   - transfer sequencer states (IDLE, LEAD, XFER, TRAIL)
//   mode_t    - latched SPI mode {cpol, cpha}
//   calc_aw   - address width for a buffer depth (at least 1 bit)
//   calc_csw  - chip-select index width for a line count (at least 1 bit)
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEAD  = 2'd1,
        XFER  = 2'd2,
        TRAIL = 2'd3
    } state_t;

    typedef struct packed {
        logic cpol;
        logic cpha;
    } mode_t;

    function automatic int calc_aw(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int calc_csw(input int ncs);
        return (ncs > 1) ? $clog2(ncs) : 1;
    endfunction

endpackage

// File: rtl/spi_master_buf_if.sv
// Host bus and SPI pin bundle for spi_master_buf.
// Modports:
//   master - host side: drives buffer access, transfer request, mode, cs_sel
//            and the slave-returned miso; observes out/busy/done and SPI pins.
//   slave  - the spi_master_buf block itself.
// Optional macro SPI_LOOPBACK_EN adds the loopback request signal.
interface spi_master_buf_if
    import spi_pkg::*;
#(
    parameter int DW    = 8,
    parameter int DEPTH = 8,
    parameter int NCS   = 2
);
    localparam int AW  = calc_aw(DEPTH);
    localparam int CSW = calc_csw(NCS);

    logic           enable;
    logic           read_write_;
    logic [AW-1:0]  madd;
    logic [DW-1:0]  data;
    logic [DW-1:0]  out;
    logic           strans;
    logic [AW:0]    count;
    logic           cpol;
    logic           cpha;
    logic [CSW-1:0] cs_sel;
    logic           busy;
    logic           done;
    logic           mclk;
    logic           mosi;
    logic           miso;
    logic [NCS-1:0] cs;
`ifdef SPI_LOOPBACK_EN
    logic           loopback;
`endif

    modport master (
        output enable, read_write_, madd, data, strans, count,
        output cpol, cpha, cs_sel, miso,
`ifdef SPI_LOOPBACK_EN
        output loopback,
`endif
        input  out, busy, done, mclk, mosi, cs
    );

    modport slave (
        input  enable, read_write_, madd, data, strans, count,
        input  cpol, cpha, cs_sel, miso,
`ifdef SPI_LOOPBACK_EN
        input  loopback,
`endif
        output out, busy, done, mclk, mosi, cs
    );

endinterface

// File: rtl/spi_clkgen.sv
// SPI clock generator: a DIV-cycle down-counter that ticks once per mclk
// half-period while a transfer is active, toggles mclk on ticks during XFER
// and classifies each toggle as a leading or trailing edge.
// Ports:
//   clk, rst      system clock, synchronous active-high reset
//   i_active      transfer in progress (any state other than IDLE)
//   i_xfer        sequencer is in XFER
//   i_cpol_idle   live cpol, followed by mclk while idle
//   i_cpol_lat    cpol latched at transfer start
//   o_tick        end of a DIV-cycle period
//   o_lead        mclk is leaving its idle level this cycle
//   o_trail       mclk is returning to its idle level this cycle
//   o_mclk        SPI clock
module spi_clkgen #(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_active,
    input  logic i_xfer,
    input  logic i_cpol_idle,
    input  logic i_cpol_lat,
    output logic o_tick,
    output logic o_lead,
    output logic o_trail,
    output logic o_mclk
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] r_cnt;
    logic          r_mclk;
    logic          w_tick;

    // Counter is parked at DIV-1 while idle so LEAD lasts exactly DIV cycles.
    assign w_tick = i_active && (r_cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= CW'(DIV - 1);
            r_mclk <= 1'b0;
        end else begin
            if (!i_active || (r_cnt == '0)) begin
                r_cnt <= CW'(DIV - 1);
            end else begin
                r_cnt <= r_cnt - CW'(1);
            end

            if (!i_active) begin
                r_mclk <= i_cpol_idle;
            end else if (i_xfer && w_tick) begin
                r_mclk <= ~r_mclk;
            end
        end
    end

    assign o_tick  = w_tick;
    assign o_lead  = i_xfer && w_tick && (r_mclk == i_cpol_lat);
    assign o_trail = i_xfer && w_tick && (r_mclk != i_cpol_lat);
    assign o_mclk  = r_mclk;

endmodule

// File: rtl/spi_master_buf.sv
// Buffered SPI master: host fills a DEPTH x DW TX buffer, requests a transfer
// of up to DEPTH words on one of NCS chip selects, then reads the received
// words back from the RX buffer by address.
// Ports:
//   clk, rst   system clock, synchronous active-high reset
//   bus        spi_master_buf_if.slave: buffer access (enable, read_write_,
//              madd, data, out), transfer control (strans, count, cpol, cpha,
//              cs_sel, busy, done) and SPI pins (mclk, mosi, miso, cs)
// Optional macro SPI_LOOPBACK_EN: adds bus.loopback, latched at transfer
// start; when set the receive path samples the internal mosi instead of miso.
//
// state | meaning
// IDLE  | waiting for strans with count != 0; mclk follows live cpol
// LEAD  | cs asserted, first MSB on mosi, DIV cycles before the first edge
// XFER  | 2*DW mclk edges per word, words back to back
// TRAIL | mclk idle, DIV cycles before cs release and done
module spi_master_buf
    import spi_pkg::*;
#(
    parameter int DW    = 8,
    parameter int DEPTH = 8,
    parameter int NCS   = 2,
    parameter int DIV   = 2
) (
    input  logic            clk,
    input  logic            rst,
    spi_master_buf_if.slave bus
);
    localparam int AW  = calc_aw(DEPTH);
    localparam int CSW = calc_csw(NCS);
    localparam int BW  = calc_aw(DW);

    state_t         r_state;
    state_t         w_next;
    mode_t          r_mode;
    logic [AW:0]    r_n;
    logic [AW-1:0]  r_word;
    logic [BW-1:0]  r_bit;
    logic [DW-1:0]  r_tx_sh;
    logic [DW-1:0]  r_rx_sh;
    logic           r_mosi;
    logic [NCS-1:0] r_cs;
    logic           r_busy;
    logic           r_done;
    logic [DW-1:0]  r_out;
    logic [DW-1:0]  r_tx [DEPTH];
    logic [DW-1:0]  r_rx [DEPTH];

    logic           w_tick;
    logic           w_lead;
    logic           w_trail;
    logic           w_mclk;
    logic           w_accept;
    logic [AW:0]    w_n_clamp;
    logic [NCS-1:0] w_cs_dec;
    logic           w_sin;
    logic           w_sample;
    logic           w_last_bit;
    logic           w_last_word;
    logic [AW-1:0]  w_word_nxt;
    logic [DW-1:0]  w_rx_next;

`ifdef SPI_LOOPBACK_EN
    logic r_lb;
    assign w_sin = r_lb ? r_mosi : bus.miso;
`else
    assign w_sin = bus.miso;
`endif

    spi_clkgen #(.DIV(DIV)) u_clkgen (
        .clk         (clk),
        .rst         (rst),
        .i_active    (r_state != IDLE),
        .i_xfer      (r_state == XFER),
        .i_cpol_idle (bus.cpol),
        .i_cpol_lat  (r_mode.cpol),
        .o_tick      (w_tick),
        .o_lead      (w_lead),
        .o_trail     (w_trail),
        .o_mclk      (w_mclk)
    );

    assign w_accept    = (r_state == IDLE) && bus.strans && (bus.count != '0);
    assign w_n_clamp   = (bus.count > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : bus.count;
    assign w_sample    = r_mode.cpha ? w_trail : w_lead;
    assign w_rx_next   = {r_rx_sh[DW-2:0], w_sin};
    // r_bit counts down to 0; the trailing edge at 0 closes a word.
    assign w_last_bit  = w_trail && (r_bit == '0);
    assign w_last_word = ({1'b0, r_word} == (r_n - (AW+1)'(1)));
    assign w_word_nxt  = r_word + AW'(1);

    // An out-of-range cs_sel leaves every line deasserted.
    always_comb begin
        w_cs_dec = '1;
        for (int i = 0; i < NCS; i++) begin
            if (bus.cs_sel == CSW'(i)) begin
                w_cs_dec[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = LEAD;
            LEAD:    if (w_tick) w_next = XFER;
            XFER:    if (w_last_bit && w_last_word) w_next = TRAIL;
            TRAIL:   if (w_tick) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode  <= '0;
            r_n     <= '0;
            r_word  <= '0;
            r_bit   <= '0;
            r_tx_sh <= '0;
            r_rx_sh <= '0;
            r_mosi  <= 1'b0;
            r_cs    <= '1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
`ifdef SPI_LOOPBACK_EN
            r_lb    <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_mode.cpol <= bus.cpol;
                        r_mode.cpha <= bus.cpha;
                        r_n         <= w_n_clamp;
                        r_word      <= '0;
                        r_bit       <= BW'(DW - 1);
                        r_tx_sh     <= r_tx[0];
                        r_mosi      <= r_tx[0][DW-1];
                        r_cs        <= w_cs_dec;
                        r_busy      <= 1'b1;
`ifdef SPI_LOOPBACK_EN
                        r_lb        <= bus.loopback;
`endif
                    end
                end
                XFER: begin
                    if (w_sample) begin
                        r_rx_sh <= w_rx_next;
                    end
                    // CPHA=1 presents each bit on the leading edge.
                    if (w_lead && r_mode.cpha) begin
                        r_mosi <= r_tx_sh[DW-1];
                    end
                    if (w_trail) begin
                        if (r_bit == '0) begin
                            r_bit   <= BW'(DW - 1);
                            r_word  <= w_word_nxt;
                            r_tx_sh <= r_tx[w_word_nxt];
                            if (!r_mode.cpha) begin
                                r_mosi <= r_tx[w_word_nxt][DW-1];
                            end
                        end else begin
                            r_bit   <= r_bit - BW'(1);
                            r_tx_sh <= {r_tx_sh[DW-2:0], 1'b0};
                            if (!r_mode.cpha) begin
                                r_mosi <= r_tx_sh[DW-2];
                            end
                        end
                    end
                end
                TRAIL: begin
                    if (w_tick) begin
                        r_cs   <= '1;
                        r_busy <= 1'b0;
                        r_done <= 1'b1;
                        r_mosi <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (bus.enable && !bus.read_write_ && !r_busy) begin
            r_tx[bus.madd] <= bus.data;
        end
    end

    // With CPHA=1 the final bit is sampled on the same edge that closes the word.
    always_ff @(posedge clk) begin
        if ((r_state == XFER) && w_last_bit) begin
            r_rx[r_word] <= r_mode.cpha ? w_rx_next : r_rx_sh;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out <= '0;
        end else if (bus.enable && bus.read_write_) begin
            r_out <= r_rx[bus.madd];
        end
    end

    assign bus.out  = r_out;
    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.mclk = w_mclk;
    assign bus.mosi = r_mosi;
    assign bus.cs   = r_cs;

endmodule

// File: tb/tb_spi_master_buf.sv
// Directed bench for spi_master_buf (DW=8, DEPTH=8, NCS=2, DIV=2) with a
// behavioural SPI slave on cs[0] that returns 16'hA53C and records mosi.
module tb_spi_master_buf;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    spi_master_buf_if #(.DW(8), .DEPTH(8), .NCS(2)) bus ();

    spi_master_buf #(.DW(8), .DEPTH(8), .NCS(2), .DIV(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // slave model
    logic        sl_miso = 1'b0;
    logic [15:0] sl_data = 16'hA53C;
    logic [15:0] sl_cap  = '0;
    int          sl_bit  = 0;
    logic        sl_cs_q = 1'b1;
    logic        sl_mclk_q = 1'b0;
    logic        tb_cpol = 1'b0;
    logic        tb_cpha = 1'b0;

    assign bus.miso = sl_miso;

    always @(bus.mclk or bus.cs) begin
        if (bus.cs[0] !== sl_cs_q) begin
            sl_cs_q = bus.cs[0];
            if (bus.cs[0] === 1'b0) begin
                sl_bit = 0;
                sl_cap = '0;
                if (!tb_cpha) sl_miso = sl_data[15];
            end
        end else if (bus.cs[0] === 1'b0 && bus.mclk !== sl_mclk_q) begin
            if (bus.mclk !== tb_cpol) begin
                if (!tb_cpha) sl_cap = {sl_cap[14:0], bus.mosi};
                else if (sl_bit < 16) sl_miso = sl_data[15-sl_bit];
            end else begin
                if (!tb_cpha) begin
                    sl_bit++;
                    if (sl_bit < 16) sl_miso = sl_data[15-sl_bit];
                end else begin
                    sl_cap = {sl_cap[14:0], bus.mosi};
                    sl_bit++;
                end
            end
        end
        sl_mclk_q = bus.mclk;
    end

    // per-transfer observations filled by drive_xfer
    int   m_done_k;
    int   m_dones;
    int   m_low;
    int   m_other;
    logic m_busy1;
    logic m_mclk1;

    task automatic drive_xfer(input logic [3:0] cnt, input logic pol, input logic pha,
                              input logic sel, input int inj_k, input int max_k);
        @(negedge clk);
        bus.cpol = pol; bus.cpha = pha; bus.cs_sel = sel; bus.count = cnt;
        tb_cpol = pol; tb_cpha = pha;
        @(negedge clk);
        bus.strans = 1'b1;
        m_done_k = -1; m_dones = 0; m_low = 0; m_other = 0;
        for (int k = 1; k <= max_k; k++) begin
            @(negedge clk);
            if (k == 1) begin
                m_busy1 = bus.busy;
                m_mclk1 = bus.mclk;
                bus.strans = 1'b0;
            end
            for (int i = 0; i < 2; i++) begin
                if (bus.cs[i] === 1'b0) begin
                    if (i == int'(sel)) m_low++;
                    else m_other++;
                end
            end
            if (bus.done === 1'b1) begin
                m_dones++;
                if (m_done_k < 0) m_done_k = k;
            end
            if (k == inj_k) begin
                bus.strans = 1'b1;
                bus.enable = 1'b1; bus.read_write_ = 1'b0; bus.madd = 3'd1; bus.data = 8'hFF;
            end
            if (k == inj_k + 1) begin
                bus.strans = 1'b0;
                bus.enable = 1'b0;
            end
        end
    endtask

    task automatic write_tx(input logic [2:0] a, input logic [7:0] d);
        @(negedge clk);
        bus.enable = 1'b1; bus.read_write_ = 1'b0; bus.madd = a; bus.data = d;
        @(negedge clk);
        bus.enable = 1'b0;
    endtask

    task automatic read_rx(input logic [2:0] a, output logic [7:0] v);
        @(negedge clk);
        bus.enable = 1'b1; bus.read_write_ = 1'b1; bus.madd = a;
        @(negedge clk);
        v = bus.out;
        bus.enable = 1'b0; bus.read_write_ = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] tx_vals [8];
        tx_vals = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
        repeat (3) @(negedge clk);
        rst = 1'b0;
        n_cmp++; if (bus.cs !== 2'b11) begin n_bad++; $display("FAIL reset_cs: got %b expected 11", bus.cs); end
        n_cmp++; if (bus.mclk !== 1'b0) begin n_bad++; $display("FAIL reset_mclk: got %b expected 0", bus.mclk); end
        n_cmp++; if (bus.mosi !== 1'b0) begin n_bad++; $display("FAIL reset_mosi: got %b expected 0", bus.mosi); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b expected 0", bus.done); end
        n_cmp++; if (bus.out !== 8'h00) begin n_bad++; $display("FAIL reset_out: got %h expected 00", bus.out); end
        for (int i = 0; i < 8; i++) write_tx(3'(i), tx_vals[i]);
        n_cmp++; if (bus.out !== 8'h00) begin n_bad++; $display("FAIL write_out: got %h expected 00", bus.out); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL write_busy: got %b expected 0", bus.busy); end
        n_cmp++; if (bus.cs !== 2'b11) begin n_bad++; $display("FAIL write_cs: got %b expected 11", bus.cs); end
    endtask

    task automatic test_modes();
        logic [7:0] v0, v1;
        logic pol, pha;
        for (int m = 0; m < 4; m++) begin
            pol = m[1]; pha = m[0];
            drive_xfer(4'd2, pol, pha, 1'b0, 0, 100);
            read_rx(3'd0, v0);
            read_rx(3'd1, v1);
            n_cmp++; if (m_done_k - 1 != 68) begin n_bad++; $display("FAIL mode%0d_len: got %0d expected 68", m, m_done_k - 1); end
            n_cmp++; if (m_low != 68) begin n_bad++; $display("FAIL mode%0d_cs0_low: got %0d expected 68", m, m_low); end
            n_cmp++; if (m_other != 0) begin n_bad++; $display("FAIL mode%0d_cs1_low: got %0d expected 0", m, m_other); end
            n_cmp++; if (m_dones != 1) begin n_bad++; $display("FAIL mode%0d_done_cnt: got %0d expected 1", m, m_dones); end
            n_cmp++; if (m_busy1 !== 1'b1) begin n_bad++; $display("FAIL mode%0d_busy: got %b expected 1", m, m_busy1); end
            n_cmp++; if (m_mclk1 !== pol) begin n_bad++; $display("FAIL mode%0d_mclk_idle: got %b expected %b", m, m_mclk1, pol); end
            n_cmp++; if (bus.mclk !== pol) begin n_bad++; $display("FAIL mode%0d_mclk_end: got %b expected %b", m, bus.mclk, pol); end
            n_cmp++; if (sl_cap !== 16'h1234) begin n_bad++; $display("FAIL mode%0d_mosi: got %h expected 1234", m, sl_cap); end
            n_cmp++; if (v0 !== 8'hA5) begin n_bad++; $display("FAIL mode%0d_rx0: got %h expected a5", m, v0); end
            n_cmp++; if (v1 !== 8'h3C) begin n_bad++; $display("FAIL mode%0d_rx1: got %h expected 3c", m, v1); end
        end
    endtask

    task automatic test_busy_ignore();
        drive_xfer(4'd2, 1'b0, 1'b0, 1'b0, 10, 140);
        n_cmp++; if (m_dones != 1) begin n_bad++; $display("FAIL busy_done_cnt: got %0d expected 1", m_dones); end
        n_cmp++; if (m_done_k - 1 != 68) begin n_bad++; $display("FAIL busy_len: got %0d expected 68", m_done_k - 1); end
        n_cmp++; if (sl_cap !== 16'h1234) begin n_bad++; $display("FAIL busy_tx_kept: got %h expected 1234", sl_cap); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL busy_end: got %b expected 0", bus.busy); end
    endtask

    task automatic test_count_edges();
        drive_xfer(4'd0, 1'b0, 1'b0, 1'b0, 0, 20);
        n_cmp++; if (m_busy1 !== 1'b0) begin n_bad++; $display("FAIL cnt0_busy: got %b expected 0", m_busy1); end
        n_cmp++; if (m_low + m_other != 0) begin n_bad++; $display("FAIL cnt0_cs: got %0d low cycles expected 0", m_low + m_other); end
        n_cmp++; if (m_dones != 0) begin n_bad++; $display("FAIL cnt0_done: got %0d expected 0", m_dones); end
        drive_xfer(4'd15, 1'b0, 1'b0, 1'b1, 0, 300);
        n_cmp++; if (m_done_k - 1 != 260) begin n_bad++; $display("FAIL cnt15_len: got %0d expected 260", m_done_k - 1); end
        n_cmp++; if (m_low != 260) begin n_bad++; $display("FAIL cnt15_cs1_low: got %0d expected 260", m_low); end
        n_cmp++; if (m_other != 0) begin n_bad++; $display("FAIL cnt15_cs0_low: got %0d expected 0", m_other); end
        n_cmp++; if (m_dones != 1) begin n_bad++; $display("FAIL cnt15_done_cnt: got %0d expected 1", m_dones); end
    endtask

    task automatic test_reset_mid();
        int dones;
        logic [7:0] v0, v1, e0, e1;
        @(negedge clk);
        bus.cpol = 1'b1; bus.cpha = 1'b0; bus.cs_sel = 1'b0; bus.count = 4'd2;
        tb_cpol = 1'b1; tb_cpha = 1'b0;
        @(negedge clk);
        bus.strans = 1'b1;
        @(negedge clk);
        bus.strans = 1'b0;
        repeat (18) @(negedge clk);
        n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL rstmid_pre_busy: got %b expected 1", bus.busy); end
        rst = 1'b1;
        @(negedge clk);
        n_cmp++; if (bus.cs !== 2'b11) begin n_bad++; $display("FAIL rstmid_cs: got %b expected 11", bus.cs); end
        n_cmp++; if (bus.mclk !== 1'b0) begin n_bad++; $display("FAIL rstmid_mclk: got %b expected 0", bus.mclk); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy: got %b expected 0", bus.busy); end
        n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL rstmid_done: got %b expected 0", bus.done); end
        n_cmp++; if (bus.mosi !== 1'b0) begin n_bad++; $display("FAIL rstmid_mosi: got %b expected 0", bus.mosi); end
        n_cmp++; if (bus.out !== 8'h00) begin n_bad++; $display("FAIL rstmid_out: got %h expected 00", bus.out); end
        rst = 1'b0;
        dones = 0;
        repeat (80) begin
            @(negedge clk);
            if (bus.done === 1'b1) dones++;
        end
        n_cmp++; if (dones != 0) begin n_bad++; $display("FAIL rstmid_no_done: got %0d expected 0", dones); end
`ifdef SPI_LOOPBACK_EN
        bus.loopback = 1'b1;
        e0 = 8'h12; e1 = 8'h34;
`else
        e0 = 8'hA5; e1 = 8'h3C;
`endif
        drive_xfer(4'd2, 1'b0, 1'b0, 1'b0, 0, 100);
        read_rx(3'd0, v0);
        read_rx(3'd1, v1);
        n_cmp++; if (m_dones != 1) begin n_bad++; $display("FAIL follow_done_cnt: got %0d expected 1", m_dones); end
        n_cmp++; if (v0 !== e0) begin n_bad++; $display("FAIL follow_rx0: got %h expected %h", v0, e0); end
        n_cmp++; if (v1 !== e1) begin n_bad++; $display("FAIL follow_rx1: got %h expected %h", v1, e1); end
    endtask

    initial begin
        bus.enable = 1'b0; bus.read_write_ = 1'b0; bus.madd = '0; bus.data = '0;
        bus.strans = 1'b0; bus.count = '0; bus.cpol = 1'b0; bus.cpha = 1'b0;
        bus.cs_sel = '0;
`ifdef SPI_LOOPBACK_EN
        bus.loopback = 1'b0;
`endif
        test_reset();
        test_modes();
        test_busy_ignore();
        test_count_edges();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
